// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int COLS  = 4;
  localparam int ROWS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB,
    ST_HELD,
    ST_REL
  } state_e;

  typedef enum logic [1:0] {
    DEC_NONE,
    DEC_SINGLE,
    DEC_MULTI
  } dec_e;

endpackage

// File: rtl/keypad_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous inputs.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, ghost rejection, debounce and one-entry key buffer.
// Optional auto-repeat of a held key is built when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 2
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_SCANS = 8
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [COLS-1:0]  V,
  input  logic [ROWS-1:0]  H,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_down,
  output logic             key_ovf
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DCNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE);
  localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);

  logic [DIV_W-1:0]      div_q;
  logic [1:0]            col_q;
  logic [COLS-1:0]       v_q;
  logic [ROWS-1:0]       hSync;
  logic [3*ROWS-1:0]     snap_q;
  logic [COLS*ROWS-1:0]  snapNow;
  logic                  lastDwell;
  logic                  scanDone;

  dec_e                  decRes;
  logic [KEY_W-1:0]      decIdx;
  logic                  isCand;

  state_e                state_q, state_d;
  logic [KEY_W-1:0]      cand_q, cand_d;
  logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
  logic [DCNT_W-1:0]     dcntInc;
  logic                  emitPress;
  logic                  emitRepeat;
  logic                  emitAny;
  logic [KEY_W-1:0]      emitCode;

  logic [KEY_W-1:0]      code_q, code_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;

  keypad_sync #(.WIDTH(ROWS)) u_sync (
    .clk_i  (CLK),
    .rst_ni (RST),
    .d_i    (H),
    .q_o    (hSync)
  );

  assign lastDwell = (div_q == DIV_LAST);
  assign scanDone  = lastDwell && (col_q == 2'd3);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q  <= '0;
      col_q  <= '0;
      v_q    <= 4'b0001;
      snap_q <= '0;
    end else if (lastDwell) begin
      div_q <= '0;
      col_q <= col_q + 2'd1;
      v_q   <= {v_q[COLS-2:0], v_q[COLS-1]};
      case (col_q)
        2'd0:    snap_q[3:0]  <= hSync;
        2'd1:    snap_q[7:4]  <= hSync;
        2'd2:    snap_q[11:8] <= hSync;
        default: ;
      endcase
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Column 3 is sampled on the very cycle the scan completes, so it bypasses the snapshot register.
  assign snapNow = {hSync, snap_q};

  always_comb begin
    decRes = DEC_NONE;
    decIdx = '0;
    for (int i = 0; i < COLS * ROWS; i++) begin
      if (snapNow[i]) begin
        if (decRes == DEC_NONE) begin
          decRes = DEC_SINGLE;
          decIdx = KEY_W'(i);
        end else begin
          decRes = DEC_MULTI;
        end
      end
    end
  end

  assign isCand  = (decRes == DEC_SINGLE) && (decIdx == cand_q);
  assign dcntInc = dcnt_q + DCNT_ONE;

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    dcnt_d    = dcnt_q;
    emitPress = 1'b0;
    emitCode  = cand_q;
    if (scanDone) begin
      case (state_q)
        ST_IDLE: begin
          if (decRes == DEC_SINGLE) begin
            cand_d   = decIdx;
            emitCode = decIdx;
            if (DEBOUNCE == 1) begin
              emitPress = 1'b1;
              state_d   = ST_HELD;
            end else begin
              dcnt_d  = DCNT_ONE;
              state_d = ST_DEB;
            end
          end
        end
        ST_DEB: begin
          if (isCand) begin
            dcnt_d = dcntInc;
            if (dcntInc == DCNT_MAX) begin
              emitPress = 1'b1;
              state_d   = ST_HELD;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!isCand) begin
            if (DEBOUNCE == 1) begin
              state_d = ST_IDLE;
            end else begin
              dcnt_d  = DCNT_ONE;
              state_d = ST_REL;
            end
          end
        end
        ST_REL: begin
          if (decRes == DEC_SINGLE) begin
            state_d = isCand ? ST_HELD : ST_IDLE;
          end else begin
            dcnt_d = dcntInc;
            if (dcntInc == DCNT_MAX) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      dcnt_q  <= dcnt_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_SCANS);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [RPT_W-1:0] rptInc;
  logic             holdTick;

  assign holdTick = scanDone && (state_q == ST_HELD) && isCand;
  assign rptInc   = rpt_q + RPT_W'(1);

  // Held outside HELD at zero, so every entry into HELD starts a fresh repeat interval.
  always_comb begin
    rpt_d      = rpt_q;
    emitRepeat = 1'b0;
    if (state_q != ST_HELD) begin
      rpt_d = '0;
    end else if (holdTick) begin
      if (rptInc == RPT_MAX) begin
        emitRepeat = 1'b1;
        rpt_d      = '0;
      end else begin
        rpt_d = rptInc;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  assign emitRepeat = 1'b0;
`endif

  assign emitAny = emitPress || emitRepeat;

  // A new key is only dropped when the buffer is full and not being drained this cycle.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovf_d   = 1'b0;
    if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
    if (emitAny) begin
      if (!valid_q || key_ready) begin
        code_d  = emitCode;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign V         = v_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_ovf   = ovf_q;
  assign key_down  = (state_q == ST_HELD) || (state_q == ST_REL);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner: models the key matrix on V/H and checks emissions.
module tb_keypad_scanner;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  V;
  logic [3:0]  H;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_down;
  logic        key_ovf;

  logic [15:0] pressMask;
  int          cyc = 0;
  int          emitCount = 0;
  int          ovfCount = 0;
  int          lastEmitCyc = 0;
  logic [3:0]  lastCode = '0;
  logic        downSeen = 1'b0;
  int          assertCount = 0;
  int          failCount = 0;

  keypad_scanner dut (
    .CLK       (CLK),
    .RST       (RST),
    .V         (V),
    .H         (H),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down),
    .key_ovf   (key_ovf)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // A closed switch at (col c, row r) ties H[r] to V[c].
  always_comb begin
    H = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressMask[4*c + r] && V[c]) H[r] = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      if (key_valid && key_ready) begin
        emitCount   <= emitCount + 1;
        lastCode    <= key_code;
        lastEmitCyc <= cyc;
      end
      if (key_ovf) ovfCount <= ovfCount + 1;
      if (key_down) downSeen <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input int cycles);
    pressMask = mask;
    tick(cycles);
  endtask

  task automatic waitKeyUp(input string tag);
    int n;
    n = 0;
    while (key_down && n < 51) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 32'(key_down), 32'd0);
  endtask

  initial begin
    int base;
    int baseOvf;
    int pressCyc;
    int lat;

    RST       = 1'b0;
    key_ready = 1'b1;
    pressMask = '0;
    tick(3);
    checkOutput("reset_V", 32'(V), 32'd1);
    checkOutput("reset_valid", 32'(key_valid), 32'd0);
    checkOutput("reset_down", 32'(key_down), 32'd0);
    checkOutput("reset_code", 32'(key_code), 32'd0);
    checkOutput("reset_ovf", 32'(key_ovf), 32'd0);

    RST = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("scan_V", 32'(V), 32'(1 << (i % 4)));
      tick(4);
    end
    tick(20);

    base     = emitCount;
    pressCyc = cyc;
    applyStimulus(16'h0008, 64);
    lat = lastEmitCyc - pressCyc;
    checkOutput("single_count", 32'(emitCount - base), 32'd1);
    checkOutput("single_code", 32'(lastCode), 32'd3);
    checkOutput("single_latency_in_range", 32'(lat >= 17 && lat <= 51), 32'd1);
    checkOutput("single_down", 32'(key_down), 32'd1);
    pressMask = '0;
    waitKeyUp("single_release");
    tick(20);
    checkOutput("single_no_extra", 32'(emitCount - base), 32'd1);

    base = emitCount;
    applyStimulus(16'h0200, 10);
    applyStimulus(16'h0000, 6);
    checkOutput("bounce_quiet", 32'(emitCount - base), 32'd0);
    applyStimulus(16'h0200, 64);
    checkOutput("bounce_count", 32'(emitCount - base), 32'd1);
    checkOutput("bounce_code", 32'(lastCode), 32'd9);
    pressMask = '0;
    waitKeyUp("bounce_release");
    tick(20);

    base     = emitCount;
    downSeen = 1'b0;
    applyStimulus(16'h0011, 64);
    checkOutput("ghost_no_emit", 32'(emitCount - base), 32'd0);
    checkOutput("ghost_no_down", 32'(downSeen), 32'd0);
    applyStimulus(16'h0000, 60);
    checkOutput("ghost_release_no_emit", 32'(emitCount - base), 32'd0);

    key_ready = 1'b0;
    base      = emitCount;
    baseOvf   = ovfCount;
    applyStimulus(16'h0020, 64);
    applyStimulus(16'h0000, 60);
    checkOutput("bp_valid5", 32'(key_valid), 32'd1);
    checkOutput("bp_code5", 32'(key_code), 32'd5);
    checkOutput("bp_no_ovf5", 32'(ovfCount - baseOvf), 32'd0);
    applyStimulus(16'h0040, 64);
    applyStimulus(16'h0000, 60);
    checkOutput("bp_ovf6", 32'(ovfCount - baseOvf), 32'd1);
    checkOutput("bp_code_kept", 32'(key_code), 32'd5);
    checkOutput("bp_valid_kept", 32'(key_valid), 32'd1);
    checkOutput("bp_no_transfer", 32'(emitCount - base), 32'd0);
    key_ready = 1'b1;
    tick(1);
    checkOutput("bp_drained", 32'(key_valid), 32'd0);
    tick(5);
    checkOutput("bp_stays_empty", 32'(key_valid), 32'd0);

    base = emitCount;
    applyStimulus(16'h8000, 400);
`ifdef KEYPAD_REPEAT_EN
    checkOutput("hold_emissions", 32'(emitCount - base), 32'd3);
`else
    checkOutput("hold_emissions", 32'(emitCount - base), 32'd1);
`endif
    checkOutput("hold_code", 32'(lastCode), 32'd15);
    checkOutput("hold_down", 32'(key_down), 32'd1);

    RST = 1'b0;
    #1;
    checkOutput("midreset_V", 32'(V), 32'd1);
    checkOutput("midreset_valid", 32'(key_valid), 32'd0);
    checkOutput("midreset_down", 32'(key_down), 32'd0);
    checkOutput("midreset_code", 32'(key_code), 32'd0);
    checkOutput("midreset_ovf", 32'(key_ovf), 32'd0);
    tick(3);
    RST  = 1'b1;
    base = emitCount;
    tick(100);
    checkOutput("reemit_count", 32'(emitCount - base), 32'd1);
    checkOutput("reemit_code", 32'(lastCode), 32'd15);
    pressMask = '0;
    waitKeyUp("reemit_release");
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
